// File: rtl/bn_vec_packer.sv
// Packs a stream of fp16 elements into size-wide vectors for the batch-norm array.
// One output holding register plus the fill register as a second buffer under backpressure.
module bn_vec_packer #(
  parameter int unsigned size       = 8,
  parameter int unsigned channel    = 2,
  localparam int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [0:DATA_WIDTH*size-1]   out_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_padded,
  output logic [15:0]                  vec_count
);

  localparam int unsigned IdxW = (size > 1) ? $clog2(size) : 1;
  localparam int unsigned VecW = DATA_WIDTH * size;

  if (channel == 0 || (size % channel) != 0) begin : gen_bad_cfg
    $error("bn_vec_packer: size must be a non-zero multiple of channel");
  end

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e                             state_q, state_d;
  logic [IdxW-1:0]                    idx_q, idx_d;
  logic [size-1:0][DATA_WIDTH-1:0]    fill_q, fill_d, fill_next;
  logic                               fill_pad_q, fill_pad_d;
  logic [0:VecW-1]                    out_vec_q, out_vec_d;
  logic                               out_valid_q, out_valid_d;
  logic                               out_padded_q, out_padded_d;
  logic [15:0]                        vec_count_q, vec_count_d;

  logic accept, at_end, complete, early, consume, hold_free;

  function automatic logic [0:VecW-1] pack_vec(input logic [size-1:0][DATA_WIDTH-1:0] v);
    logic [0:VecW-1] r;
    r = '0;
    for (int unsigned k = 0; k < size; k++) begin
      r[k*DATA_WIDTH +: DATA_WIDTH] = v[k];
    end
    return r;
  endfunction

  always_comb begin
    accept    = (state_q == StFill) && in_valid;
    at_end    = (idx_q == IdxW'(size - 1));
    complete  = accept && (at_end || in_last);
    early     = complete && !at_end;
    consume   = out_valid_q && out_ready;
    hold_free = !out_valid_q || out_ready;

    // Current element lands in slot idx; an early last zeroes every slot above it.
    for (int unsigned k = 0; k < size; k++) begin
      fill_next[k] = fill_q[k];
      if (IdxW'(k) == idx_q) begin
        fill_next[k] = in_data;
      end else if (early && (IdxW'(k) > idx_q)) begin
        fill_next[k] = '0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    fill_pad_d   = fill_pad_q;
    out_vec_d    = out_vec_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_padded_d = out_padded_q;
    vec_count_d  = vec_count_q + 16'(consume);

    unique case (state_q)
      StFill: begin
        if (accept) begin
          fill_d = fill_next;
          idx_d  = idx_q + IdxW'(1);
          if (complete) begin
            idx_d      = '0;
            fill_pad_d = early;
            if (hold_free) begin
              out_vec_d    = pack_vec(fill_next);
              out_padded_d = early;
              out_valid_d  = 1'b1;
            end else begin
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        // out_valid is always set here, so out_ready alone means a handoff.
        if (out_ready) begin
          out_vec_d    = pack_vec(fill_q);
          out_padded_d = fill_pad_q;
          out_valid_d  = 1'b1;
          idx_d        = '0;
          state_d      = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFill;
      idx_q        <= '0;
      fill_q       <= '0;
      fill_pad_q   <= 1'b0;
      out_vec_q    <= '0;
      out_valid_q  <= 1'b0;
      out_padded_q <= 1'b0;
      vec_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      fill_pad_q   <= fill_pad_d;
      out_vec_q    <= out_vec_d;
      out_valid_q  <= out_valid_d;
      out_padded_q <= out_padded_d;
      vec_count_q  <= vec_count_d;
    end
  end

  assign in_ready   = (state_q == StFill);
  assign out_vec    = out_vec_q;
  assign out_valid  = out_valid_q;
  assign out_padded = out_padded_q;
  assign vec_count  = vec_count_q;

endmodule
